// File: rtl/exc_commit_ctrl_pkg.sv
// Purpose : shared commit-point types: exception flag vector, cause codes, FSM states.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package cpuDefine;

    // Flags are listed in resolution priority order, highest first (MSB = adef).
    typedef struct packed {
        logic adef;
        logic tlbr_f;
        logic pif;
        logic ppi_f;
        logic ine;
        logic ipe;
        logic sys;
        logic brk;
        logic ale;
        logic adem;
        logic tlbr_m;
        logic pil;
        logic pis;
        logic pme;
        logic ppi_m;
    } exc_vec_t;

    localparam logic [5:0] ECODE_INT       = 6'h00;
    localparam logic [5:0] ECODE_PIL       = 6'h01;
    localparam logic [5:0] ECODE_PIS       = 6'h02;
    localparam logic [5:0] ECODE_PIF       = 6'h03;
    localparam logic [5:0] ECODE_PME       = 6'h04;
    localparam logic [5:0] ECODE_PPI       = 6'h07;
    localparam logic [5:0] ECODE_ADEF_ADEM = 6'h08;
    localparam logic [5:0] ECODE_ALE       = 6'h09;
    localparam logic [5:0] ECODE_SYS       = 6'h0B;
    localparam logic [5:0] ECODE_BRK       = 6'h0C;
    localparam logic [5:0] ECODE_INE       = 6'h0D;
    localparam logic [5:0] ECODE_IPE       = 6'h0E;
    localparam logic [5:0] ECODE_TLBR      = 6'h3F;

    localparam logic [8:0] ESUB_ADEF       = 9'd0;
    localparam logic [8:0] ESUB_ADEM       = 9'd1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_COMMIT,
        ST_DRAIN,
        ST_HALT
    } commit_state_t;

    // Source of the BADV value captured alongside a cause.
    typedef enum logic [1:0] {
        BADV_ZERO,
        BADV_PC,
        BADV_ADDR
    } badv_sel_t;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Purpose : resolves interrupt + exception flags into one cause {vld, excode, esubcode, badv_sel}.
// Latency : combinational.
// Backpr. : none.
// Ports   : exc_vec/int_pend in; enc_vld, enc_excode, enc_esubcode, enc_badv_sel out.
module exc_prio_enc
    import cpuDefine::*;
(
    input  exc_vec_t         exc_vec,
    input  logic             int_pend,
    output logic             enc_vld,
    output logic [5:0]       enc_excode,
    output logic [8:0]       enc_esubcode,
    output badv_sel_t        enc_badv_sel
);

    always_comb begin
        enc_vld      = 1'b1;
        enc_excode   = ECODE_INT;
        enc_esubcode = 9'd0;
        enc_badv_sel = BADV_ZERO;
        if (int_pend) begin
            enc_excode = ECODE_INT;
        end else if (exc_vec.adef) begin
            enc_excode   = ECODE_ADEF_ADEM;
            enc_esubcode = ESUB_ADEF;
            enc_badv_sel = BADV_PC;
        end else if (exc_vec.tlbr_f) begin
            enc_excode   = ECODE_TLBR;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.pif) begin
            enc_excode   = ECODE_PIF;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.ppi_f) begin
            enc_excode   = ECODE_PPI;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.ine) begin
            enc_excode = ECODE_INE;
        end else if (exc_vec.ipe) begin
            enc_excode = ECODE_IPE;
        end else if (exc_vec.sys) begin
            enc_excode = ECODE_SYS;
        end else if (exc_vec.brk) begin
            enc_excode = ECODE_BRK;
        end else if (exc_vec.ale) begin
            enc_excode   = ECODE_ALE;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.adem) begin
            enc_excode   = ECODE_ADEF_ADEM;
            enc_esubcode = ESUB_ADEM;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.tlbr_m) begin
            enc_excode   = ECODE_TLBR;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.pil) begin
            enc_excode   = ECODE_PIL;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.pis) begin
            enc_excode   = ECODE_PIS;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.pme) begin
            enc_excode   = ECODE_PME;
            enc_badv_sel = BADV_ADDR;
        end else if (exc_vec.ppi_m) begin
            enc_excode   = ECODE_PPI;
            enc_badv_sel = BADV_ADDR;
        end else begin
            enc_vld = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Purpose : commit-point sequencer turning exc/int/ertn/refetch/idle into one CSR event pulse.
// Latency : accept in N, pulse in N+1, flush N+1..N+2, next accept no earlier than N+3.
// Backpr. : wb_ready (state-only) drops from the commit cycle until the drain completes.
// Ports   : clk/reset; wb_* retiring instruction in, wb_ready out; ie/lie/is interrupt status;
//           is_exc/is_ertn/is_fetch_again pulses with excode/esubcode/badvaddr/csr_pc; flush; halted.
// Config  : EXC_COMMIT_IDLE_EN adds the HALT state so `idle` parks the core until an interrupt.
module exc_commit_ctrl
    import cpuDefine::*;
#(
    parameter logic [31:0] PC_RESET = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  exc_vec_t    wb_exc,
    input  logic [31:0] wb_badv,
    input  logic        wb_is_ertn,
    input  logic        wb_is_refetch,
    input  logic        wb_is_idle,
    input  logic        ie,
    input  logic [11:0] lie,
    input  logic [11:0] is,
    output logic        is_exc,
    output logic [5:0]  excode,
    output logic [8:0]  esubcode,
    output logic [31:0] badvaddr,
    output logic [31:0] csr_pc,
    output logic        is_ertn,
    output logic        is_fetch_again,
    output logic        flush,
    output logic        halted
);

    commit_state_t state_q, state_d;
    logic          is_exc_q, is_exc_d;
    logic          is_ertn_q, is_ertn_d;
    logic          fa_q, fa_d;
    logic          flush_q, flush_d;
    logic          halted_q, halted_d;
    logic [5:0]    excode_q, excode_d;
    logic [8:0]    esub_q, esub_d;
    logic [31:0]   badv_q, badv_d;
    logic [31:0]   csr_pc_q, csr_pc_d;
`ifdef EXC_COMMIT_IDLE_EN
    logic          commit_idle_q, commit_idle_d;
`else
    logic          unused_idle;
    assign unused_idle = wb_is_idle;
`endif

    logic          int_pend;
    logic          enc_vld;
    logic [5:0]    enc_excode;
    logic [8:0]    enc_esubcode;
    badv_sel_t     enc_badv_sel;

    assign int_pend = ie & (|(lie & is));

    exc_prio_enc u_prio_enc (
        .exc_vec      (wb_exc),
        .int_pend     (int_pend),
        .enc_vld      (enc_vld),
        .enc_excode   (enc_excode),
        .enc_esubcode (enc_esubcode),
        .enc_badv_sel (enc_badv_sel)
    );

    always_comb begin
        state_d   = state_q;
        is_exc_d  = 1'b0;
        is_ertn_d = 1'b0;
        fa_d      = 1'b0;
        excode_d  = excode_q;
        esub_d    = esub_q;
        badv_d    = badv_q;
        csr_pc_d  = csr_pc_q;
`ifdef EXC_COMMIT_IDLE_EN
        commit_idle_d = commit_idle_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (wb_valid) begin
                    if (enc_vld) begin
                        state_d  = ST_COMMIT;
                        is_exc_d = 1'b1;
                        excode_d = enc_excode;
                        esub_d   = enc_esubcode;
                        csr_pc_d = wb_pc;
                        case (enc_badv_sel)
                            BADV_PC:   badv_d = wb_pc;
                            BADV_ADDR: badv_d = wb_badv;
                            default:   badv_d = 32'd0;
                        endcase
                    end else if (wb_is_ertn) begin
                        state_d   = ST_COMMIT;
                        is_ertn_d = 1'b1;
                        csr_pc_d  = wb_pc;
                    end else if (wb_is_refetch) begin
                        state_d  = ST_COMMIT;
                        fa_d     = 1'b1;
                        csr_pc_d = wb_pc;
                    end
`ifdef EXC_COMMIT_IDLE_EN
                    else if (wb_is_idle) begin
                        // No pulse now; csr_pc already holds the resume PC for the wake-up interrupt.
                        state_d       = ST_COMMIT;
                        commit_idle_d = 1'b1;
                        csr_pc_d      = wb_pc + 32'd4;
                    end
`endif
                end
            end
            ST_COMMIT: begin
`ifdef EXC_COMMIT_IDLE_EN
                state_d       = commit_idle_q ? ST_HALT : ST_DRAIN;
                commit_idle_d = 1'b0;
`else
                state_d = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                state_d  = ST_RUN;
                csr_pc_d = PC_RESET;
            end
`ifdef EXC_COMMIT_IDLE_EN
            ST_HALT: begin
                if (int_pend) begin
                    state_d  = ST_COMMIT;
                    is_exc_d = 1'b1;
                    excode_d = ECODE_INT;
                    esub_d   = 9'd0;
                    badv_d   = 32'd0;
                end
            end
`endif
            default: begin
                state_d  = ST_RUN;
                csr_pc_d = PC_RESET;
            end
        endcase
        flush_d  = (state_d != ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            is_exc_q  <= 1'b0;
            is_ertn_q <= 1'b0;
            fa_q      <= 1'b0;
            flush_q   <= 1'b0;
            halted_q  <= 1'b0;
            excode_q  <= 6'd0;
            esub_q    <= 9'd0;
            badv_q    <= 32'd0;
            csr_pc_q  <= PC_RESET;
`ifdef EXC_COMMIT_IDLE_EN
            commit_idle_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            is_exc_q  <= is_exc_d;
            is_ertn_q <= is_ertn_d;
            fa_q      <= fa_d;
            flush_q   <= flush_d;
            halted_q  <= halted_d;
            excode_q  <= excode_d;
            esub_q    <= esub_d;
            badv_q    <= badv_d;
            csr_pc_q  <= csr_pc_d;
`ifdef EXC_COMMIT_IDLE_EN
            commit_idle_q <= commit_idle_d;
`endif
        end
    end

    assign wb_ready       = (state_q == ST_RUN);
    assign is_exc         = is_exc_q;
    assign is_ertn        = is_ertn_q;
    assign is_fetch_again = fa_q;
    assign flush          = flush_q;
    assign halted         = halted_q;
    assign excode         = excode_q;
    assign esubcode       = esub_q;
    assign badvaddr       = badv_q;
    assign csr_pc         = csr_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Purpose : self-checking bench for exc_commit_ctrl (vector table + expected-result queue).
// Latency : checks pulse at N+1, drain at N+2, ready at N+3.
// Backpr. : waits on wb_ready with a cycle bound before each transaction.
module tb_exc_commit_ctrl;

    localparam logic [31:0] PC_RST = 32'h1c00_0000;

    // Exception flag masks, MSB-first priority order.
    localparam logic [14:0] F_ADEF   = 15'h4000;
    localparam logic [14:0] F_TLBR_F = 15'h2000;
    localparam logic [14:0] F_PIF    = 15'h1000;
    localparam logic [14:0] F_INE    = 15'h0400;
    localparam logic [14:0] F_IPE    = 15'h0200;
    localparam logic [14:0] F_SYS    = 15'h0100;
    localparam logic [14:0] F_BRK    = 15'h0080;
    localparam logic [14:0] F_ALE    = 15'h0040;
    localparam logic [14:0] F_ADEM   = 15'h0020;
    localparam logic [14:0] F_PIL    = 15'h0008;
    localparam logic [14:0] F_PIS    = 15'h0004;
    localparam logic [14:0] F_PME    = 15'h0002;
    localparam logic [14:0] F_PPI_M  = 15'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_pc, wb_badv;
    logic [14:0] wb_exc;
    logic        wb_is_ertn, wb_is_refetch, wb_is_idle;
    logic        ie;
    logic [11:0] lie, is;
    logic        is_exc, is_ertn, is_fetch_again, flush, halted;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr, csr_pc;

    exc_commit_ctrl #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_exc(wb_exc),
        .wb_badv(wb_badv), .wb_is_ertn(wb_is_ertn), .wb_is_refetch(wb_is_refetch),
        .wb_is_idle(wb_is_idle), .ie(ie), .lie(lie), .is(is),
        .is_exc(is_exc), .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr),
        .csr_pc(csr_pc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again),
        .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] exc;
        logic        ertn;
        logic        refetch;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        ie;
        logic [11:0] lie;
        logic [11:0] is;
        logic        e_exc;
        logic        e_ertn;
        logic        e_fa;
        logic        chk_cause;
        logic [5:0]  e_code;
        logic [8:0]  e_sub;
        logic [31:0] e_badv;
        logic        chk_pc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[14];
    vec_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = 32'd0; wb_exc = 15'd0; wb_badv = 32'd0;
        wb_is_ertn = 1'b0; wb_is_refetch = 1'b0; wb_is_idle = 1'b0;
        ie = 1'b0; lie = 12'd0; is = 12'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int k = 0;
        while (!wb_ready && k < 10) begin
            step();
            k++;
        end
        chk({nm, "_ready_wait"}, {31'd0, wb_ready}, 32'd1);
    endtask

    task automatic mk(input int i, input logic [14:0] exc, input logic ertn, input logic rf,
                      input logic [31:0] pc, input logic [31:0] badv, input logic iev,
                      input logic [11:0] liev, input logic [11:0] isv,
                      input logic ee, input logic er, input logic ef, input logic cc,
                      input logic [5:0] code, input logic [8:0] sub, input logic [31:0] eb,
                      input logic cp, input logic [31:0] epc);
        vecs[i].exc = exc; vecs[i].ertn = ertn; vecs[i].refetch = rf;
        vecs[i].pc = pc; vecs[i].badv = badv; vecs[i].ie = iev;
        vecs[i].lie = liev; vecs[i].is = isv;
        vecs[i].e_exc = ee; vecs[i].e_ertn = er; vecs[i].e_fa = ef;
        vecs[i].chk_cause = cc; vecs[i].e_code = code; vecs[i].e_sub = sub;
        vecs[i].e_badv = eb; vecs[i].chk_pc = cp; vecs[i].e_pc = epc;
    endtask

    initial begin
        vec_t v;
        vec_t e;
        idle_inputs();
        reset = 1'b1;
        // exc, ertn, rf, pc, badv, ie, lie, is | exc, ertn, fa, chk_cause, code, sub, badv, chk_pc, pc
        mk(0,  F_SYS,          0,0, 32'h1c00_0100, 32'h0000_dead, 0,12'h000,12'h000, 1,0,0, 1,6'h0B,9'd0,32'h0,          1,32'h1c00_0100);
        mk(1,  F_ALE|F_ADEM,   0,0, 32'h1c00_0110, 32'h8000_0003, 0,12'h000,12'h000, 1,0,0, 1,6'h09,9'd0,32'h8000_0003,  1,32'h1c00_0110);
        mk(2,  F_ADEM,         0,0, 32'h1c00_0114, 32'h8000_0003, 0,12'h000,12'h000, 1,0,0, 1,6'h08,9'd1,32'h8000_0003,  1,32'h1c00_0114);
        mk(3,  F_INE,          0,0, 32'h1c00_0180, 32'h1234_5678, 1,12'h800,12'h800, 1,0,0, 1,6'h00,9'd0,32'h0,          1,32'h1c00_0180);
        mk(4,  15'd0,          1,0, 32'h1c00_0120, 32'h0,         0,12'h000,12'h000, 0,1,0, 0,6'h00,9'd0,32'h0,          0,32'h0);
        mk(5,  15'd0,          0,1, 32'h1c00_0200, 32'h0,         0,12'h000,12'h000, 0,0,1, 0,6'h00,9'd0,32'h0,          1,32'h1c00_0200);
        mk(6,  F_ADEF|F_SYS,   0,0, 32'h1c00_0404, 32'h5555_0000, 0,12'h000,12'h000, 1,0,0, 1,6'h08,9'd0,32'h1c00_0404,  1,32'h1c00_0404);
        mk(7,  F_TLBR_F|F_PIF, 0,0, 32'h1c00_0408, 32'h7000_1000, 0,12'h000,12'h000, 1,0,0, 1,6'h3F,9'd0,32'h7000_1000,  1,32'h1c00_0408);
        mk(8,  F_PIL|F_PIS,    0,0, 32'h1c00_040c, 32'h7000_2000, 0,12'h000,12'h000, 1,0,0, 1,6'h01,9'd0,32'h7000_2000,  1,32'h1c00_040c);
        mk(9,  F_BRK,          1,1, 32'h1c00_0410, 32'h7000_3000, 0,12'h000,12'h000, 1,0,0, 1,6'h0C,9'd0,32'h0,          1,32'h1c00_0410);
        mk(10, F_PME,          0,0, 32'h1c00_0414, 32'h7000_4000, 0,12'h000,12'h000, 1,0,0, 1,6'h04,9'd0,32'h7000_4000,  1,32'h1c00_0414);
        mk(11, F_INE,          0,0, 32'h1c00_0418, 32'h7000_5000, 0,12'hfff,12'hfff, 1,0,0, 1,6'h0D,9'd0,32'h0,          1,32'h1c00_0418);
        mk(12, F_PPI_M,        0,0, 32'h1c00_041c, 32'h7000_6000, 1,12'h004,12'h001, 1,0,0, 1,6'h07,9'd0,32'h7000_6000,  1,32'h1c00_041c);
        mk(13, F_IPE|F_SYS,    0,0, 32'h1c00_0420, 32'h7000_7000, 0,12'h000,12'h000, 1,0,0, 1,6'h0E,9'd0,32'h0,          1,32'h1c00_0420);

        step();
        step();
        reset = 1'b0;
        chk("rst_is_exc",  {31'd0, is_exc},         32'd0);
        chk("rst_is_ertn", {31'd0, is_ertn},        32'd0);
        chk("rst_fa",      {31'd0, is_fetch_again}, 32'd0);
        chk("rst_flush",   {31'd0, flush},          32'd0);
        chk("rst_halted",  {31'd0, halted},         32'd0);
        chk("rst_excode",  {26'd0, excode},         32'd0);
        chk("rst_esub",    {23'd0, esubcode},       32'd0);
        chk("rst_badv",    badvaddr,                32'd0);
        chk("rst_csr_pc",  csr_pc,                  PC_RST);
        chk("rst_ready",   {31'd0, wb_ready},       32'd1);

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            wait_ready("vec");
            wb_valid = 1'b1; wb_exc = v.exc; wb_is_ertn = v.ertn; wb_is_refetch = v.refetch;
            wb_pc = v.pc; wb_badv = v.badv; ie = v.ie; lie = v.lie; is = v.is;
            sb_q.push_back(v);
            step();
            idle_inputs();
            e = sb_q.pop_front();
            chk($sformatf("v%0d_is_exc", i),  {31'd0, is_exc},         {31'd0, e.e_exc});
            chk($sformatf("v%0d_is_ertn", i), {31'd0, is_ertn},        {31'd0, e.e_ertn});
            chk($sformatf("v%0d_fa", i),      {31'd0, is_fetch_again}, {31'd0, e.e_fa});
            if (e.chk_cause) begin
                chk($sformatf("v%0d_excode", i), {26'd0, excode},   {26'd0, e.e_code});
                chk($sformatf("v%0d_esub", i),   {23'd0, esubcode}, {23'd0, e.e_sub});
                chk($sformatf("v%0d_badv", i),   badvaddr,          e.e_badv);
            end
            if (e.chk_pc) chk($sformatf("v%0d_csr_pc", i), csr_pc, e.e_pc);
            chk($sformatf("v%0d_flush_c", i), {31'd0, flush},    32'd1);
            chk($sformatf("v%0d_ready_c", i), {31'd0, wb_ready}, 32'd0);
            step();
            chk($sformatf("v%0d_pulses_d", i), {29'd0, is_exc, is_ertn, is_fetch_again}, 32'd0);
            chk($sformatf("v%0d_flush_d", i),  {31'd0, flush},    32'd1);
            chk($sformatf("v%0d_ready_d", i),  {31'd0, wb_ready}, 32'd0);
            step();
            chk($sformatf("v%0d_ready_r", i),  {31'd0, wb_ready}, 32'd1);
            chk($sformatf("v%0d_flush_r", i),  {31'd0, flush},    32'd0);
            chk($sformatf("v%0d_pc_r", i),     csr_pc,            PC_RST);
        end

        // Plain instruction: no event, stays in RUN.
        wait_ready("plain");
        wb_valid = 1'b1; wb_pc = 32'h1c00_0500;
        step();
        idle_inputs();
        chk("plain_pulses", {29'd0, is_exc, is_ertn, is_fetch_again}, 32'd0);
        chk("plain_flush",  {31'd0, flush},    32'd0);
        chk("plain_ready",  {31'd0, wb_ready}, 32'd1);

        // idle: parks until an enabled interrupt, or retires as a plain instruction.
        wait_ready("idle");
        wb_valid = 1'b1; wb_is_idle = 1'b1; wb_pc = 32'h1c00_0300;
        step();
        idle_inputs();
`ifdef EXC_COMMIT_IDLE_EN
        ie = 1'b1; lie = 12'h004;
        chk("idle_commit_pulses", {29'd0, is_exc, is_ertn, is_fetch_again}, 32'd0);
        chk("idle_commit_flush",  {31'd0, flush}, 32'd1);
        step();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("idle_halted_%0d", c), {31'd0, halted}, 32'd1);
            step();
        end
        chk("idle_halt_flush", {31'd0, flush},    32'd1);
        chk("idle_halt_ready", {31'd0, wb_ready}, 32'd0);
        is = 12'h004;
        step();
        idle_inputs();
        chk("wake_is_exc", {31'd0, is_exc}, 32'd1);
        chk("wake_excode", {26'd0, excode}, 32'd0);
        chk("wake_csr_pc", csr_pc,          32'h1c00_0304);
        chk("wake_halted", {31'd0, halted}, 32'd0);
        step();
        step();
        chk("wake_ready", {31'd0, wb_ready}, 32'd1);
`else
        chk("idle_plain_pulses", {29'd0, is_exc, is_ertn, is_fetch_again}, 32'd0);
        chk("idle_plain_flush",  {31'd0, flush},    32'd0);
        chk("idle_plain_ready",  {31'd0, wb_ready}, 32'd1);
        chk("idle_plain_halted", {31'd0, halted},   32'd0);
`endif

        // Reset during the commit cycle drops the pulse and returns to RUN.
        wait_ready("rstc");
        wb_valid = 1'b1; wb_exc = F_SYS; wb_pc = 32'h1c00_0600;
        step();
        idle_inputs();
        chk("rstc_pulse_seen", {31'd0, is_exc}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstc_pulses", {29'd0, is_exc, is_ertn, is_fetch_again}, 32'd0);
        chk("rstc_flush",  {31'd0, flush},    32'd0);
        chk("rstc_ready",  {31'd0, wb_ready}, 32'd1);
        chk("rstc_csr_pc", csr_pc,            PC_RST);
        step();
        chk("rstc_ready2", {31'd0, wb_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
